qspi_flash_seq: RTL and testbench
=================================

Name: qspi_flash_seq

Overview:
Parametrised successor to the QSPI memory command controller. It accepts generic flash command descriptors (opcode, optional address, write payload, read length, optional completion polling) over a valid/ready handshake. It frames each command for the existing SPI shift engine and returns read data with a status code. It sits between the host-side flash register/DMA logic and the SPI shifter, and replaces the hard-coded per-opcode state list with one descriptor-driven sequence.

Parameters:
ADDR_BYTES, 3, address bytes sent when req_has_addr=1 (3 or 4)
PAGE_BYTES, 256, maximum write payload bytes per command
RX_BYTES, 8, maximum read bytes per command; rsp_rdata width is 8*RX_BYTES
TMO_W, 36, width of the poll timeout counter
POLL_OPCODE, 8'h70, status read opcode used while polling (read flag status)
POLL_BIT, 7, bit of the polled byte that signals ready when 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  command request valid
req_ready  out  1  high only in IDLE
req_opcode  in  8  command opcode
req_quad  in  1  quad I/O mode for this command
req_has_addr  in  1  send ADDR_BYTES of req_addr after the opcode
req_addr  in  8*ADDR_BYTES  address, MSByte first on the wire
req_tx_len  in  $clog2(PAGE_BYTES+1)  payload bytes
req_wdata  in  8*PAGE_BYTES  payload, left-aligned (first byte in MSBs)
req_rx_len  in  $clog2(RX_BYTES+1)  bytes to read
req_poll  in  1  poll until ready after the command completes
req_tmo  in  TMO_W  maximum poll attempts
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  8*RX_BYTES  read data, last byte in [7:0]
rsp_err  out  2  0 OK, 1 poll timeout, 2 bad length
busy  out  1  high whenever not IDLE
phy_start  out  1  one-cycle start pulse to the shifter
phy_quad  out  1  quad mode to the shifter
phy_tx_data  out  8*(1+ADDR_BYTES+PAGE_BYTES)  frame, opcode in MSByte
phy_tx_count  out  $clog2(2+ADDR_BYTES+PAGE_BYTES)  bytes to send
phy_rx_count  out  $clog2(RX_BYTES+1)  bytes to receive
phy_busy  in  1  shifter busy
phy_rx_data  in  8*RX_BYTES  received bytes, last byte in [7:0]

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; busy=0; rsp_valid=0; rsp_err=0; rsp_rdata=0; phy_start=0; phy_quad=0; phy_tx_data, phy_tx_count and phy_rx_count = 0; poll counter=0. Reset mid-command aborts at once. Flash state after an aborted command is the host's problem.
- States: IDLE, ISSUE, WAIT, POLL_ISSUE, POLL_WAIT, DONE (plus WREN/WREN_WAIT with the optional feature).
- IDLE: on req_valid&&req_ready, latch the descriptor.
  - If req_tx_len>PAGE_BYTES or req_rx_len>RX_BYTES, go to DONE with err=2 and issue no phy_start.
  - Otherwise go to ISSUE.
- ISSUE: drive the frame {opcode, addr if has_addr, payload}, left-aligned. phy_tx_count = 1 + (has_addr ? ADDR_BYTES : 0) + tx_len. phy_rx_count = rx_len. Pulse phy_start for one cycle, then go to WAIT.
- WAIT: ignore phy_busy in the cycle phy_start is high. When phy_start=0 and phy_busy=0, capture phy_rx_data into rsp_rdata.
  - If poll is set, load the counter with req_tmo and go to POLL_ISSUE.
  - Otherwise go to DONE with err=0.
- POLL_ISSUE:
  - If counter==0, go to DONE with err=1. This includes req_tmo=0, which times out without polling.
  - Otherwise send POLL_OPCODE with tx_count=1 and rx_count=1, decrement the counter, and go to POLL_WAIT.
- POLL_WAIT: on completion, if phy_rx_data[POLL_BIT]=1 go to DONE with err=0; otherwise go back to POLL_ISSUE. rsp_rdata keeps the main command's read data, not the poll bytes.
- DONE: rsp_valid=1 for exactly one cycle, rsp_err valid in that cycle, then IDLE. rsp_rdata and rsp_err hold until the next DONE.
- Minimum latency, accept to rsp_valid, is 3 cycles plus shifter time.
- req_valid while busy is not accepted and must be held by the requester.
- phy_quad = latched req_quad for all frames of the command, including polls.

Optional Feature:
QSPI_SEQ_AUTO_WREN_EN.
- Defined: an accepted request with req_poll=1 first sends a 1-byte 8'h06 (write enable) frame via WREN, then waits for completion in WREN_WAIT, then proceeds to ISSUE.
- Undefined: no automatic write enable; the host issues 8'h06 as a separate request.

Decomposition:
- Package qspi_pkg holds: opcode constants (WREN 8'h06, RFSR 8'h70, PP 8'h02, SE 8'hD8, BE 8'hC7, RDID 8'h9F), the error code enum, the state enum, and a descriptor struct typedef.
- No sub-module. The existing SPI shifter is instantiated alongside at the parent level, not inside this block.

Test Plan:
- RDID: opcode 9F, has_addr=0, rx_len=3, shifter model returns 20 BA 18 -> one phy_start with tx_count=1, rx_count=3; rsp_rdata[23:0]=20BA18; err=0.
- Page program: 02, addr 0x012345, tx_len=256, poll=1, tmo=10; status not ready twice then 0x80 -> tx_count=260; three POLL_OPCODE frames; err=0.
- Timeout: sector erase D8, poll=1, tmo=4, status always 0x00 -> exactly 4 poll frames, then err=1.
- Bad length: rx_len=RX_BYTES+1 -> no phy_start; rsp_valid within 2 cycles; err=2.
- Reset mid-poll: drop rst_n during POLL_WAIT -> all outputs at reset values immediately; next request executes normally.
- With QSPI_SEQ_AUTO_WREN_EN: erase request -> first frame opcode 06 with tx_count=1, then D8 frame.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared opcodes, status codes, sequencer states and the latched command
// descriptor for the QSPI flash command sequencer.
package qspi_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RFSR = 8'h70;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_BE   = 8'hC7;
  localparam logic [7:0] OP_RDID = 8'h9F;

  typedef enum logic [1:0] {
    ERR_OK  = 2'd0,
    ERR_TMO = 2'd1,
    ERR_LEN = 2'd2
  } qspi_err_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT       = 3'd2,
    ST_POLL_ISSUE = 3'd3,
    ST_POLL_WAIT  = 3'd4,
    ST_DONE       = 3'd5,
    ST_WREN       = 3'd6,
    ST_WREN_WAIT  = 3'd7
  } qspi_state_e;

  typedef struct packed {
    logic [7:0] opcode;
    logic       quad;
    logic       has_addr;
    logic       poll;
  } qspi_desc_t;

endpackage

// File: rtl/qspi_flash_seq.sv
// Descriptor-driven QSPI flash command sequencer feeding the SPI shift engine.
// Optional macro QSPI_SEQ_AUTO_WREN_EN: prefix polled commands with a write enable.
module qspi_flash_seq
  import qspi_pkg::*;
#(
  parameter int         ADDR_BYTES  = 3,
  parameter int         PAGE_BYTES  = 256,
  parameter int         RX_BYTES    = 8,
  parameter int         TMO_W       = 36,
  parameter logic [7:0] POLL_OPCODE = OP_RFSR,
  parameter int         POLL_BIT    = 7
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [7:0]                                  req_opcode,
  input  logic                                        req_quad,
  input  logic                                        req_has_addr,
  input  logic [8*ADDR_BYTES-1:0]                     req_addr,
  input  logic [$clog2(PAGE_BYTES+1)-1:0]             req_tx_len,
  input  logic [8*PAGE_BYTES-1:0]                     req_wdata,
  input  logic [$clog2(RX_BYTES+1)-1:0]               req_rx_len,
  input  logic                                        req_poll,
  input  logic [TMO_W-1:0]                            req_tmo,
  output logic                                        rsp_valid,
  output logic [8*RX_BYTES-1:0]                       rsp_rdata,
  output logic [1:0]                                  rsp_err,
  output logic                                        busy,
  output logic                                        phy_start,
  output logic                                        phy_quad,
  output logic [8*(1+ADDR_BYTES+PAGE_BYTES)-1:0]      phy_tx_data,
  output logic [$clog2(2+ADDR_BYTES+PAGE_BYTES)-1:0]  phy_tx_count,
  output logic [$clog2(RX_BYTES+1)-1:0]               phy_rx_count,
  input  logic                                        phy_busy,
  input  logic [8*RX_BYTES-1:0]                       phy_rx_data
);

  localparam int TXL_W   = $clog2(PAGE_BYTES+1);
  localparam int RXL_W   = $clog2(RX_BYTES+1);
  localparam int CNT_W   = $clog2(2+ADDR_BYTES+PAGE_BYTES);
  localparam int FRAME_W = 8*(1+ADDR_BYTES+PAGE_BYTES);
  localparam int PAD_W   = 8*(ADDR_BYTES+PAGE_BYTES);
  localparam int ADDR_W  = 8*ADDR_BYTES;
  localparam int DATA_W  = 8*PAGE_BYTES;
  localparam int RX_W    = 8*RX_BYTES;

  qspi_state_e             state_r, state_s;
  qspi_desc_t              desc_r, desc_s;
  logic [ADDR_W-1:0]       addr_r, addr_s;
  logic [TXL_W-1:0]        tx_len_r, tx_len_s;
  logic [DATA_W-1:0]       wdata_r, wdata_s;
  logic [RXL_W-1:0]        rx_len_r, rx_len_s;
  logic [TMO_W-1:0]        tmo_r, tmo_s;
  logic [TMO_W-1:0]        poll_cnt_r, poll_cnt_s;
  logic                    rsp_valid_r, rsp_valid_s;
  logic [RX_W-1:0]         rsp_rdata_r, rsp_rdata_s;
  qspi_err_e               rsp_err_r, rsp_err_s;
  logic                    phy_start_r, phy_start_s;
  logic                    phy_quad_r, phy_quad_s;
  logic [FRAME_W-1:0]      phy_tx_data_r, phy_tx_data_s;
  logic [CNT_W-1:0]        phy_tx_count_r, phy_tx_count_s;
  logic [RXL_W-1:0]        phy_rx_count_r, phy_rx_count_s;
  logic                    phy_done_s;

  // The shifter's busy is not yet valid in the cycle the start pulse is out.
  assign phy_done_s = !phy_start_r && !phy_busy;

  // Next-state and next-output decode for the command sequence.
  always_comb begin
    state_s        = state_r;
    desc_s         = desc_r;
    addr_s         = addr_r;
    tx_len_s       = tx_len_r;
    wdata_s        = wdata_r;
    rx_len_s       = rx_len_r;
    tmo_s          = tmo_r;
    poll_cnt_s     = poll_cnt_r;
    rsp_valid_s    = 1'b0;
    rsp_rdata_s    = rsp_rdata_r;
    rsp_err_s      = rsp_err_r;
    phy_start_s    = 1'b0;
    phy_quad_s     = phy_quad_r;
    phy_tx_data_s  = phy_tx_data_r;
    phy_tx_count_s = phy_tx_count_r;
    phy_rx_count_s = phy_rx_count_r;

    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          desc_s.opcode   = req_opcode;
          desc_s.quad     = req_quad;
          desc_s.has_addr = req_has_addr;
          desc_s.poll     = req_poll;
          addr_s          = req_addr;
          tx_len_s        = req_tx_len;
          wdata_s         = req_wdata;
          rx_len_s        = req_rx_len;
          tmo_s           = req_tmo;
          if ((req_tx_len > TXL_W'(PAGE_BYTES)) || (req_rx_len > RXL_W'(RX_BYTES))) begin
            state_s     = ST_DONE;
            rsp_valid_s = 1'b1;
            rsp_err_s   = ERR_LEN;
          end else begin
            phy_quad_s = req_quad;
`ifdef QSPI_SEQ_AUTO_WREN_EN
            if (req_poll) begin
              state_s = ST_WREN;
            end else begin
              state_s = ST_ISSUE;
            end
`else
            state_s = ST_ISSUE;
`endif
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

`ifdef QSPI_SEQ_AUTO_WREN_EN
      ST_WREN: begin
        phy_start_s    = 1'b1;
        phy_tx_data_s  = {OP_WREN, {PAD_W{1'b0}}};
        phy_tx_count_s = CNT_W'(1);
        phy_rx_count_s = RXL_W'(0);
        state_s        = ST_WREN_WAIT;
      end

      ST_WREN_WAIT: begin
        if (phy_done_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_WREN_WAIT;
        end
      end
`endif

      ST_ISSUE: begin
        // Frame is left-aligned; bytes past the count are don't-care on the wire.
        if (desc_r.has_addr) begin
          phy_tx_data_s  = {desc_r.opcode, addr_r, wdata_r};
          phy_tx_count_s = CNT_W'(1) + CNT_W'(ADDR_BYTES) + CNT_W'(tx_len_r);
        end else begin
          phy_tx_data_s  = {desc_r.opcode, wdata_r, {ADDR_W{1'b0}}};
          phy_tx_count_s = CNT_W'(1) + CNT_W'(tx_len_r);
        end
        phy_rx_count_s = rx_len_r;
        phy_start_s    = 1'b1;
        state_s        = ST_WAIT;
      end

      ST_WAIT: begin
        if (phy_done_s) begin
          rsp_rdata_s = phy_rx_data;
          if (desc_r.poll) begin
            poll_cnt_s = tmo_r;
            state_s    = ST_POLL_ISSUE;
          end else begin
            state_s     = ST_DONE;
            rsp_valid_s = 1'b1;
            rsp_err_s   = ERR_OK;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_POLL_ISSUE: begin
        if (poll_cnt_r == {TMO_W{1'b0}}) begin
          state_s     = ST_DONE;
          rsp_valid_s = 1'b1;
          rsp_err_s   = ERR_TMO;
        end else begin
          phy_start_s    = 1'b1;
          phy_tx_data_s  = {POLL_OPCODE, {PAD_W{1'b0}}};
          phy_tx_count_s = CNT_W'(1);
          phy_rx_count_s = RXL_W'(1);
          poll_cnt_s     = poll_cnt_r - TMO_W'(1);
          state_s        = ST_POLL_WAIT;
        end
      end

      ST_POLL_WAIT: begin
        if (phy_done_s) begin
          if (phy_rx_data[POLL_BIT]) begin
            state_s     = ST_DONE;
            rsp_valid_s = 1'b1;
            rsp_err_s   = ERR_OK;
          end else begin
            state_s = ST_POLL_ISSUE;
          end
        end else begin
          state_s = ST_POLL_WAIT;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, descriptor and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      desc_r         <= '{opcode: 8'h00, quad: 1'b0, has_addr: 1'b0, poll: 1'b0};
      addr_r         <= {ADDR_W{1'b0}};
      tx_len_r       <= {TXL_W{1'b0}};
      wdata_r        <= {DATA_W{1'b0}};
      rx_len_r       <= {RXL_W{1'b0}};
      tmo_r          <= {TMO_W{1'b0}};
      poll_cnt_r     <= {TMO_W{1'b0}};
      rsp_valid_r    <= 1'b0;
      rsp_rdata_r    <= {RX_W{1'b0}};
      rsp_err_r      <= ERR_OK;
      phy_start_r    <= 1'b0;
      phy_quad_r     <= 1'b0;
      phy_tx_data_r  <= {FRAME_W{1'b0}};
      phy_tx_count_r <= {CNT_W{1'b0}};
      phy_rx_count_r <= {RXL_W{1'b0}};
    end else begin
      state_r        <= state_s;
      desc_r         <= desc_s;
      addr_r         <= addr_s;
      tx_len_r       <= tx_len_s;
      wdata_r        <= wdata_s;
      rx_len_r       <= rx_len_s;
      tmo_r          <= tmo_s;
      poll_cnt_r     <= poll_cnt_s;
      rsp_valid_r    <= rsp_valid_s;
      rsp_rdata_r    <= rsp_rdata_s;
      rsp_err_r      <= rsp_err_s;
      phy_start_r    <= phy_start_s;
      phy_quad_r     <= phy_quad_s;
      phy_tx_data_r  <= phy_tx_data_s;
      phy_tx_count_r <= phy_tx_count_s;
      phy_rx_count_r <= phy_rx_count_s;
    end
  end

  assign req_ready    = (state_r == ST_IDLE);
  assign busy         = (state_r != ST_IDLE);
  assign rsp_valid    = rsp_valid_r;
  assign rsp_rdata    = rsp_rdata_r;
  assign rsp_err      = rsp_err_r;
  assign phy_start    = phy_start_r;
  assign phy_quad     = phy_quad_r;
  assign phy_tx_data  = phy_tx_data_r;
  assign phy_tx_count = phy_tx_count_r;
  assign phy_rx_count = phy_rx_count_r;

endmodule

// File: tb/tb_qspi_flash_seq.sv
// Directed bench for qspi_flash_seq with a small SPI shifter model.
module tb_qspi_flash_seq;

`ifdef QSPI_SEQ_AUTO_WREN_EN
  localparam int WO = 1;
`else
  localparam int WO = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [7:0]     req_opcode;
  logic           req_quad;
  logic           req_has_addr;
  logic [23:0]    req_addr;
  logic [8:0]     req_tx_len;
  logic [2047:0]  req_wdata;
  logic [3:0]     req_rx_len;
  logic           req_poll;
  logic [35:0]    req_tmo;
  logic           rsp_valid;
  logic [63:0]    rsp_rdata;
  logic [1:0]     rsp_err;
  logic           busy;
  logic           phy_start;
  logic           phy_quad;
  logic [2079:0]  phy_tx_data;
  logic [8:0]     phy_tx_count;
  logic [3:0]     phy_rx_count;
  logic           phy_busy;
  logic [63:0]    phy_rx_data;

  qspi_flash_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_quad(req_quad), .req_has_addr(req_has_addr), .req_addr(req_addr),
    .req_tx_len(req_tx_len), .req_wdata(req_wdata), .req_rx_len(req_rx_len),
    .req_poll(req_poll), .req_tmo(req_tmo),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .phy_start(phy_start), .phy_quad(phy_quad), .phy_tx_data(phy_tx_data),
    .phy_tx_count(phy_tx_count), .phy_rx_count(phy_rx_count),
    .phy_busy(phy_busy), .phy_rx_data(phy_rx_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Shifter model: logs each frame, stays busy 3 cycles, answers polls.
  int          n_frames = 0;
  int          n_polls  = 0;
  int          poll_base = 0;
  int          not_ready_n = 0;
  logic [63:0] main_rx = 64'h0;
  logic [39:0] f_top [64];
  logic [8:0]  f_txc [64];
  logic [3:0]  f_rxc [64];
  logic        f_quad [64];
  int          busy_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phy_busy    <= 1'b0;
      busy_cnt    <= 0;
      phy_rx_data <= 64'h0;
    end else if (phy_start) begin
      f_top[n_frames % 64]  <= phy_tx_data[2079 -: 40];
      f_txc[n_frames % 64]  <= phy_tx_count;
      f_rxc[n_frames % 64]  <= phy_rx_count;
      f_quad[n_frames % 64] <= phy_quad;
      if (phy_tx_data[2079 -: 8] == 8'h70) begin
        phy_rx_data <= ((n_polls - poll_base) >= not_ready_n) ? 64'h80 : 64'h00;
        n_polls     <= n_polls + 1;
      end else begin
        phy_rx_data <= main_rx;
      end
      n_frames <= n_frames + 1;
      phy_busy <= 1'b1;
      busy_cnt <= 3;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      phy_busy <= 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  int          frame_base;
  logic        res_got;
  int          res_cycles;
  logic [1:0]  res_err;
  logic [63:0] res_rdata;

  task automatic issue_req(input logic [7:0] op, input logic quad, input logic has_addr,
                           input logic [23:0] addr, input logic [8:0] txl, input logic [7:0] b0,
                           input logic [3:0] rxl, input logic poll, input logic [35:0] tmo);
    @(negedge clk);
    req_opcode   = op;
    req_quad     = quad;
    req_has_addr = has_addr;
    req_addr     = addr;
    req_tx_len   = txl;
    req_wdata    = '0;
    req_wdata[2047 -: 8] = b0;
    req_rx_len   = rxl;
    req_poll     = poll;
    req_tmo      = tmo;
    frame_base   = n_frames;
    poll_base    = n_polls;
    check_val("ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_val("busy_accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic quad, input logic has_addr,
                         input logic [23:0] addr, input logic [8:0] txl, input logic [7:0] b0,
                         input logic [3:0] rxl, input logic poll, input logic [35:0] tmo);
    issue_req(op, quad, has_addr, addr, txl, b0, rxl, poll, tmo);
    res_got = 1'b0;
    res_cycles = 0;
    for (int i = 1; i <= 400; i++) begin
      if (rsp_valid) begin
        res_got    = 1'b1;
        res_cycles = i;
        res_err    = rsp_err;
        res_rdata  = rsp_rdata;
        break;
      end
      @(negedge clk);
    end
    check_val("rsp_seen", {63'd0, res_got}, 64'd1);
    @(negedge clk);
    check_val("rsp_one_cycle", {63'd0, rsp_valid}, 64'd0);
    check_val("ready_after", {63'd0, req_ready}, 64'd1);
  endtask

  function automatic int fi(input int k);
    return (frame_base + k) % 64;
  endfunction

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_opcode = 8'h00; req_quad = 1'b0;
    req_has_addr = 1'b0; req_addr = 24'h0; req_tx_len = 9'd0; req_wdata = '0;
    req_rx_len = 4'd0; req_poll = 1'b0; req_tmo = 36'd0;
    #22;
    check_val("rst_ready", {63'd0, req_ready}, 64'd1);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_val("rst_rsp_err", {62'd0, rsp_err}, 64'd0);
    check_val("rst_rdata", rsp_rdata, 64'd0);
    check_val("rst_phy_start", {63'd0, phy_start}, 64'd0);
    check_val("rst_txc", {55'd0, phy_tx_count}, 64'd0);
    check_val("rst_rxc", {60'd0, phy_rx_count}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RDID: no address, 3 read bytes.
    main_rx = 64'h0000_0000_0020_BA18;
    run_cmd(8'h9F, 1'b0, 1'b0, 24'h0, 9'd0, 8'h00, 4'd3, 1'b0, 36'd0);
    check_val("rdid_frames", 64'(n_frames - frame_base), 64'd1);
    check_val("rdid_top", {24'd0, f_top[fi(0)]}, 64'h9F_0000_0000);
    check_val("rdid_txc", {55'd0, f_txc[fi(0)]}, 64'd1);
    check_val("rdid_rxc", {60'd0, f_rxc[fi(0)]}, 64'd3);
    check_val("rdid_rdata", res_rdata, 64'h20BA18);
    check_val("rdid_err", {62'd0, res_err}, 64'd0);
    check_val("rdid_latency_min", {63'd0, (res_cycles >= 3)}, 64'd1);

    // Bad read length: no frame, fast response, read data untouched.
    run_cmd(8'h9F, 1'b0, 1'b0, 24'h0, 9'd0, 8'h00, 4'd9, 1'b0, 36'd0);
    check_val("badrx_frames", 64'(n_frames - frame_base), 64'd0);
    check_val("badrx_err", {62'd0, res_err}, 64'd2);
    check_val("badrx_latency", {63'd0, (res_cycles <= 2)}, 64'd1);
    check_val("badrx_rdata_hold", res_rdata, 64'h20BA18);

    // Bad write length.
    run_cmd(8'h02, 1'b0, 1'b1, 24'h0, 9'd257, 8'h00, 4'd0, 1'b0, 36'd0);
    check_val("badtx_frames", 64'(n_frames - frame_base), 64'd0);
    check_val("badtx_err", {62'd0, res_err}, 64'd2);

    // Page program, quad, two not-ready polls then ready.
    main_rx = 64'h1122_3344_5566_7788;
    not_ready_n = 2;
    run_cmd(8'h02, 1'b1, 1'b1, 24'h012345, 9'd256, 8'hA5, 4'd0, 1'b1, 36'd10);
    check_val("pp_frames", 64'(n_frames - frame_base), 64'(WO + 4));
`ifdef QSPI_SEQ_AUTO_WREN_EN
    check_val("pp_wren_top", {24'd0, f_top[fi(0)]}, 64'h06_0000_0000);
    check_val("pp_wren_txc", {55'd0, f_txc[fi(0)]}, 64'd1);
`endif
    check_val("pp_top", {24'd0, f_top[fi(WO)]}, 64'h02_0123_45A5);
    check_val("pp_txc", {55'd0, f_txc[fi(WO)]}, 64'd260);
    for (int k = 1; k <= 3; k++) begin
      check_val("pp_poll_top", {24'd0, f_top[fi(WO + k)]}, 64'h70_0000_0000);
      check_val("pp_poll_counts", {51'd0, f_txc[fi(WO + k)], f_rxc[fi(WO + k)]}, {51'd0, 9'd1, 4'd1});
      check_val("pp_poll_quad", {63'd0, f_quad[fi(WO + k)]}, 64'd1);
    end
    check_val("pp_err", {62'd0, res_err}, 64'd0);
    check_val("pp_rdata_main", res_rdata, 64'h1122_3344_5566_7788);

    // Sector erase, status never ready: exactly 4 polls then timeout.
    main_rx = 64'h0;
    not_ready_n = 1000000;
    run_cmd(8'hD8, 1'b0, 1'b1, 24'h100000, 9'd0, 8'h00, 4'd0, 1'b1, 36'd4);
    check_val("se_frames", 64'(n_frames - frame_base), 64'(WO + 5));
`ifdef QSPI_SEQ_AUTO_WREN_EN
    check_val("se_wren_top", {24'd0, f_top[fi(0)]}, 64'h06_0000_0000);
`endif
    check_val("se_top", {24'd0, f_top[fi(WO)]}, 64'hD8_1000_0000);
    check_val("se_txc", {55'd0, f_txc[fi(WO)]}, 64'd4);
    check_val("se_polls", 64'(n_polls - poll_base), 64'd4);
    check_val("se_err", {62'd0, res_err}, 64'd1);

    // Zero timeout: times out with no poll frame.
    run_cmd(8'hC7, 1'b0, 1'b0, 24'h0, 9'd0, 8'h00, 4'd0, 1'b1, 36'd0);
    check_val("tmo0_frames", 64'(n_frames - frame_base), 64'(WO + 1));
    check_val("tmo0_err", {62'd0, res_err}, 64'd1);

    // Reset asserted while waiting on a poll.
    main_rx = 64'hCAFE;
    issue_req(8'hD8, 1'b1, 1'b1, 24'h200000, 9'd0, 8'h00, 4'd0, 1'b1, 36'd1000);
    res_got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((n_polls - poll_base) >= 2) begin
        res_got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("midpoll_reached", {63'd0, res_got}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_ready", {63'd0, req_ready}, 64'd1);
    check_val("midrst_busy", {63'd0, busy}, 64'd0);
    check_val("midrst_rdata", rsp_rdata, 64'd0);
    check_val("midrst_err", {62'd0, rsp_err}, 64'd0);
    check_val("midrst_start_quad", {62'd0, phy_start, phy_quad}, 64'd0);
    check_val("midrst_counts", {51'd0, phy_tx_count, phy_rx_count}, 64'd0);
    check_val("midrst_txdata", {24'd0, phy_tx_data[2079 -: 40]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    main_rx = 64'h0000_0000_00C2_2017;
    run_cmd(8'h9F, 1'b0, 1'b0, 24'h0, 9'd0, 8'h00, 4'd3, 1'b0, 36'd0);
    check_val("post_rst_frames", 64'(n_frames - frame_base), 64'd1);
    check_val("post_rst_rdata", res_rdata, 64'hC22017);
    check_val("post_rst_err", {62'd0, res_err}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
